// File: rtl/ft64_parcel_aligner.sv
// Fetch-to-decode aligner: queues 16-bit parcels, finds instruction boundaries,
// expands compressed parcels and presents one aligned instruction per handshake.
module ft64_parcel_aligner #(
  parameter int unsigned AMSB  = 31,
  parameter logic [AMSB:0] RSTPC = 32'hFFFC0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_v_i,
  output logic            fetch_rdy_o,
  input  logic [AMSB:0]   fetch_adr_i,
  input  logic [63:0]     fetch_dat_i,
  input  logic            flush_i,
  input  logic [AMSB:0]   flush_pc_i,
  output logic [15:0]     exp_cinstr_o,
  input  logic [47:0]     exp_expand_i,
  output logic            ins_v_o,
  input  logic            ins_rdy_i,
  output logic [47:0]     ins_o,
  output logic [AMSB:0]   ins_pc_o,
  output logic [1:0]      ins_len_o
);

  localparam int unsigned AW     = AMSB + 1;
  localparam int unsigned QDEPTH = 8;
  localparam int unsigned CW     = 4;
  localparam int unsigned PW     = 16;

  logic [PW-1:0] q     [QDEPTH];
  logic [PW-1:0] q_nxt [QDEPTH];
  logic [PW-1:0] fp    [4];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    skip;
  logic [AMSB:0] hpc;

  logic [1:0]    hlen;
  logic          head_ok;
  logic          out_free;
  logic          load;
  logic          enq;
  logic [CW-1:0] deq_len;
  logic [CW-1:0] keep;
  logic [CW-1:0] add_n;
  logic [CW-1:0] src;
  logic [CW-1:0] pos;
  logic [47:0]   ins_nxt;

  logic          unused_bits;
  assign unused_bits = ^{fetch_adr_i, flush_pc_i[0]};

  // Fetch word split into parcels, parcel 0 at the lowest address.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fp[k] = fetch_dat_i[PW*k +: PW];
    end
  end

  assign exp_cinstr_o = q[0];
  assign fetch_rdy_o  = (cnt <= CW'(4)) & ~rst;

  // Length decode of the head parcel.
  always_comb begin
    hlen = 2'd1;
    if (q[0][7]) begin
      hlen = q[0][6] ? 2'd3 : 2'd2;
    end
  end

  always_comb begin
    head_ok  = (cnt != '0) && (cnt >= CW'(hlen));
    out_free = ~ins_v_o | ins_rdy_i;
    load     = head_ok & out_free;
    enq      = fetch_v_i & fetch_rdy_o & ~flush_i;
    deq_len  = load ? CW'(hlen) : '0;
    keep     = cnt - deq_len;
    add_n    = enq ? (CW'(4) - CW'(skip)) : '0;
    cnt_nxt  = keep + add_n;
  end

  // Next queue image: shift out the dequeued head, then append the kept fetch parcels.
  always_comb begin
    src = '0;
    pos = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      src      = CW'(i) + deq_len;
      q_nxt[i] = (src < CW'(QDEPTH)) ? q[src[2:0]] : '0;
    end
    if (enq) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) >= skip) begin
          pos              = keep + CW'(k) - CW'(skip);
          q_nxt[pos[2:0]]  = fp[k];
        end
      end
    end
  end

  // Compressed parcels go through the expander; longer forms come straight from the queue.
  always_comb begin
    ins_nxt = '0;
    case (hlen)
      2'd1:    ins_nxt = exp_expand_i;
      2'd2:    ins_nxt = {16'h0000, q[1], q[0]};
      default: ins_nxt = {q[2], q[1], q[0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q[i] <= '0;
      end
      cnt       <= '0;
      skip      <= '0;
      hpc       <= RSTPC;
      ins_v_o   <= 1'b0;
      ins_o     <= '0;
      ins_pc_o  <= '0;
      ins_len_o <= '0;
    end else if (flush_i) begin
      // Redirect: drop everything, remember which parcels of the next word to skip.
      cnt     <= '0;
      skip    <= flush_pc_i[2:1];
      hpc     <= {flush_pc_i[AMSB:1], 1'b0};
      ins_v_o <= 1'b0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
      if (enq) begin
        skip <= '0;
      end
      if (load) begin
        hpc       <= hpc + AW'({hlen, 1'b0});
        ins_v_o   <= 1'b1;
        ins_o     <= ins_nxt;
        ins_pc_o  <= hpc;
        ins_len_o <= hlen;
      end else if (ins_rdy_i) begin
        ins_v_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ft64_parcel_aligner.sv
// Directed bench for ft64_parcel_aligner: reset, straddle, backpressure,
// redirects and mid-stream reset, with a simple expander model.
module tb_ft64_parcel_aligner;

  localparam logic [31:0] RSTPC = 32'hFFFC0100;

  logic        clk;
  logic        rst;
  logic        fetch_v;
  logic        fetch_rdy;
  logic [31:0] fetch_adr;
  logic [63:0] fetch_dat;
  logic        flush;
  logic [31:0] flush_pc;
  logic [15:0] exp_cinstr;
  logic [47:0] exp_expand;
  logic        ins_v;
  logic        ins_rdy;
  logic [47:0] ins_o;
  logic [31:0] ins_pc;
  logic [1:0]  ins_len;

  int n_chk = 0;
  int n_bad = 0;
  int widx;
  int j;
  logic acc;

  ft64_parcel_aligner dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_v_i    (fetch_v),
    .fetch_rdy_o  (fetch_rdy),
    .fetch_adr_i  (fetch_adr),
    .fetch_dat_i  (fetch_dat),
    .flush_i      (flush),
    .flush_pc_i   (flush_pc),
    .exp_cinstr_o (exp_cinstr),
    .exp_expand_i (exp_expand),
    .ins_v_o      (ins_v),
    .ins_rdy_i    (ins_rdy),
    .ins_o        (ins_o),
    .ins_pc_o     (ins_pc),
    .ins_len_o    (ins_len)
  );

  function automatic logic [47:0] xp(input logic [15:0] c);
    return {16'hEE00, c, ~c};
  endfunction

  assign exp_expand = xp(exp_cinstr);

  // Word k holds two 32-bit instructions, numbered 2k and 2k+1.
  function automatic logic [63:0] bpw(input int k);
    logic [15:0] p0, p1, p2, p3;
    p0 = {8'(2 * k), 8'h80};
    p1 = 16'(32'h1000 + 2 * k);
    p2 = {8'(2 * k + 1), 8'h80};
    p3 = 16'(32'h1000 + 2 * k + 1);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [47:0] bpi(input int n);
    return {16'h0000, 16'(32'h1000 + n), 8'(n), 8'h80};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_v = 1'b0; fetch_adr = '0; fetch_dat = '0;
    flush = 1'b0; flush_pc = '0; ins_rdy = 1'b1;

    // Reset and four back-to-back compressed instructions
    tick();
    tick();
    check("rst_v", 64'(ins_v), 64'd0);
    check("rst_rdy", 64'(fetch_rdy), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_rdy_after", 64'(fetch_rdy), 64'd1);
    fetch_v = 1'b1; fetch_adr = RSTPC; fetch_dat = 64'h0002_0001_0000_001F;
    tick();
    fetch_v = 1'b0;
    check("t1_cinstr", 64'(exp_cinstr), 64'h001F);
    check("t1_lat_v", 64'(ins_v), 64'd0);
    begin
      logic [15:0] par [4];
      par[0] = 16'h001F; par[1] = 16'h0000; par[2] = 16'h0001; par[3] = 16'h0002;
      for (int k = 0; k < 4; k++) begin
        tick();
        check("t1_v", 64'(ins_v), 64'd1);
        check("t1_ins", 64'(ins_o), 64'(xp(par[k])));
        check("t1_pc", 64'(ins_pc), 64'(RSTPC + 32'(2 * k)));
        check("t1_len", 64'(ins_len), 64'd1);
      end
    end
    tick();
    check("t1_drain", 64'(ins_v), 64'd0);

    // Straddling 48-bit instruction
    fetch_v = 1'b1; fetch_dat = 64'h00C0_1234_0080_0001;
    tick();
    fetch_v = 1'b0;
    tick();
    check("t2_c_ins", 64'(ins_o), 64'(xp(16'h0001)));
    check("t2_c_pc", 64'(ins_pc), 64'h0000_0000_FFFC_0108);
    tick();
    check("t2_w_ins", 64'(ins_o), 64'h0000_0000_1234_0080);
    check("t2_w_len", 64'(ins_len), 64'd2);
    check("t2_w_pc", 64'(ins_pc), 64'h0000_0000_FFFC_010A);
    tick();
    check("t2_wait0", 64'(ins_v), 64'd0);
    tick();
    check("t2_wait1", 64'(ins_v), 64'd0);
    fetch_v = 1'b1; fetch_dat = 64'h0004_0003_BBBB_AAAA;
    tick();
    fetch_v = 1'b0;
    check("t2_wait2", 64'(ins_v), 64'd0);
    tick();
    check("t2_s_v", 64'(ins_v), 64'd1);
    check("t2_s_ins", 64'(ins_o), 64'h0000_BBBB_AAAA_00C0);
    check("t2_s_len", 64'(ins_len), 64'd3);
    check("t2_s_pc", 64'(ins_pc), 64'h0000_0000_FFFC_010E);
    tick();
    check("t2_n1_ins", 64'(ins_o), 64'(xp(16'h0003)));
    check("t2_n1_pc", 64'(ins_pc), 64'h0000_0000_FFFC_0114);
    tick();
    check("t2_n2_ins", 64'(ins_o), 64'(xp(16'h0004)));
    check("t2_n2_pc", 64'(ins_pc), 64'h0000_0000_FFFC_0116);
    tick();
    check("t2_drain", 64'(ins_v), 64'd0);

    // Backpressure: 10+ stalled cycles, then release and collect all eight
    ins_rdy = 1'b0; widx = 0; j = 0;
    for (int c = 0; c < 60 && j < 8; c++) begin
      if (c == 12) begin
        check("t3_full_rdy", 64'(fetch_rdy), 64'd0);
        check("t3_fed", 64'(widx), 64'd2);
        ins_rdy = 1'b1;
      end
      fetch_v = (widx < 4); fetch_dat = bpw(widx);
      if (ins_v && ins_rdy) begin
        check("t3_ins", 64'(ins_o), 64'(bpi(j)));
        check("t3_pc", 64'(ins_pc), 64'(32'hFFFC0118 + 32'(4 * j)));
        check("t3_len", 64'(ins_len), 64'd2);
        j++;
      end else if (ins_v) begin
        check("t3_hold", {16'(ins_o), ins_pc, 14'd0, ins_len},
              {16'(bpi(0)), 32'hFFFC0118, 14'd0, 2'd2});
      end
      acc = fetch_v && fetch_rdy;
      tick();
      if (acc) widx++;
    end
    fetch_v = 1'b0;
    check("t3_count", 64'(j), 64'd8);
    tick();
    check("t3_drain", 64'(ins_v), 64'd0);

    // Mid-word redirect with six parcels queued
    ins_rdy = 1'b0;
    fetch_v = 1'b1; fetch_dat = bpw(0);
    tick();
    fetch_dat = bpw(1);
    tick();
    fetch_v = 1'b0;
    check("t4_full", 64'(fetch_rdy), 64'd0);
    flush = 1'b1; flush_pc = 32'h1006; ins_rdy = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_v", 64'(ins_v), 64'd0);
    check("t4_rdy", 64'(fetch_rdy), 64'd1);
    fetch_v = 1'b1; fetch_adr = 32'h1000; fetch_dat = 64'h0005_CAFE_BEEF_DEAD;
    tick();
    fetch_v = 1'b0;
    check("t4_lat", 64'(ins_v), 64'd0);
    tick();
    check("t4_first_v", 64'(ins_v), 64'd1);
    check("t4_first_pc", 64'(ins_pc), 64'h1006);
    check("t4_first_ins", 64'(ins_o), 64'(xp(16'h0005)));
    check("t4_first_len", 64'(ins_len), 64'd1);
    tick();
    check("t4_only_p3", 64'(ins_v), 64'd0);

    // Flush colliding with a fetch word and a ready decode
    fetch_v = 1'b1; fetch_dat = 64'h0014_0013_0012_0011;
    tick();
    fetch_v = 1'b0;
    tick();
    check("t5_pre", 64'(ins_v), 64'd1);
    flush = 1'b1; flush_pc = 32'h2000; fetch_v = 1'b1;
    fetch_dat = 64'h0024_0023_0022_0021;
    tick();
    flush = 1'b0; fetch_v = 1'b0;
    check("t5_v", 64'(ins_v), 64'd0);
    tick();
    tick();
    check("t5_drop", 64'(ins_v), 64'd0);
    fetch_v = 1'b1; fetch_adr = 32'h2000; fetch_dat = 64'h0034_0033_0032_0031;
    tick();
    fetch_v = 1'b0;
    tick();
    check("t5_first_pc", 64'(ins_pc), 64'h2000);
    check("t5_first_ins", 64'(ins_o), 64'(xp(16'h0031)));
    for (int k = 0; k < 4; k++) tick();
    check("t5_drain", 64'(ins_v), 64'd0);

    // Reset with a valid output and five parcels queued
    ins_rdy = 1'b0;
    fetch_v = 1'b1; fetch_dat = 64'h0041_2222_1111_00C0;
    tick();
    fetch_dat = 64'h0045_0044_0043_0042;
    tick();
    fetch_v = 1'b0;
    check("t6_pre_v", 64'(ins_v), 64'd1);
    check("t6_pre_ins", 64'(ins_o), 64'h0000_2222_1111_00C0);
    rst = 1'b1;
    tick();
    check("t6_v", 64'(ins_v), 64'd0);
    check("t6_ins", 64'(ins_o), 64'd0);
    check("t6_pc", 64'(ins_pc), 64'd0);
    check("t6_len", 64'(ins_len), 64'd0);
    check("t6_rdy_rst", 64'(fetch_rdy), 64'd0);
    rst = 1'b0; ins_rdy = 1'b1;
    #1;
    check("t6_rdy", 64'(fetch_rdy), 64'd1);
    fetch_v = 1'b1; fetch_adr = RSTPC; fetch_dat = 64'h0000_0000_0000_0051;
    tick();
    fetch_v = 1'b0;
    tick();
    check("t6_hpc", 64'(ins_pc), 64'(RSTPC));
    check("t6_ins_after", 64'(ins_o), 64'(xp(16'h0051)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
